// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encodings, counter width and fault causes.
// Honours MEM_ALIGN_ERR_EN: when defined, odd byte addresses are reported as faults.
package mem_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } memStateT;

  localparam int CNT_W = 4;

  localparam logic [1:0] FAULT_NONE  = 2'd0;
  localparam logic [1:0] FAULT_RANGE = 2'd1;
  localparam logic [1:0] FAULT_ALIGN = 2'd2;

  // Range beats alignment when both apply; either one suppresses the access.
  function automatic logic [1:0] faultCause(input logic [15:0] a, input int unsigned depth);
    faultCause = FAULT_NONE;
`ifdef MEM_ALIGN_ERR_EN
    if (a[0]) faultCause = FAULT_ALIGN;
`else
    faultCause = FAULT_NONE;
`endif
    if (32'(a[15:1]) >= depth) faultCause = FAULT_RANGE;
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x 16 word storage: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency data-memory responder for the pipeline memory stage (stall/done protocol).
// Build option MEM_ALIGN_ERR_EN (see mem_defs) turns odd addresses into faults.
module mem_responder
  import mem_defs::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [1:0]  dbgState
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  memStateT         state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             latWr;
  logic [15:0]      latAddr, latWdata;
  logic             accWr;
  logic [15:0]      accAddr, accWdata;
  logic             accFault, enterResp, memWe;
  logic [15:0]      memRd;

  // Handshake: req_en is the request valid and stall is its inverted ready. A request is taken
  // on the edge where state==IDLE and req_en=1; the initiator then holds it until done pulses.

  // With LATENCY==1 the RESP edge follows the accept edge directly, so use the live inputs.
  always_comb begin
    accWr    = latWr;
    accAddr  = latAddr;
    accWdata = latWdata;
    if (state == IDLE) begin
      accWr    = req_wr;
      accAddr  = addr;
      accWdata = wdata;
    end
  end

  assign accFault = (faultCause(accAddr, $unsigned(DEPTH)) != FAULT_NONE);

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        stall = req_en;
        if (req_en) stateNext = (LATENCY == 1) ? RESP : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == CNT_W'(1)) stateNext = RESP;
      end
      RESP: begin
        done      = 1'b1;
        err       = (faultCause(latAddr, $unsigned(DEPTH)) != FAULT_NONE);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign enterResp = (stateNext == RESP) && (state != RESP);
  // The array has no reset, so hold its write port shut while rst is high.
  assign memWe     = enterResp && accWr && !accFault && !rst;
  assign dbgState  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      latWr    <= 1'b0;
      latAddr  <= '0;
      latWdata <= '0;
      rdata    <= '0;
    end else begin
      if (state == IDLE && req_en) begin
        latWr    <= req_wr;
        latAddr  <= addr;
        latWdata <= wdata;
        cnt      <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enterResp && !accWr) rdata <= accFault ? 16'h0000 : memRd;
    end
  end

  mem_array #(.DEPTH(DEPTH), .AW(AW)) uArray (
    .clk   (clk),
    .we    (memWe),
    .idx   (accAddr[AW:1]),
    .wdata (accWdata),
    .rdata (memRd)
  );

endmodule
